// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the two-master arbiter: bus widths,
// arbiter state encoding and the request/response bundles used by the muxes.
package wb_pkg;

    localparam int WB_ADDR_W              = 32;
    localparam int WB_DATA_W              = 32;
    localparam int WB_SEL_W               = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] dat;
        logic                 we;
        logic [WB_SEL_W-1:0]  sel;
        logic                 cyc;
        logic                 stb;
        logic                 lock;
    } wb_req_t;

    typedef struct packed {
        logic [WB_DATA_W-1:0] dat;
        logic                 ack;
        logic                 err;
        logic                 rty;
    } wb_rsp_t;

    localparam wb_rsp_t RSP_IDLE = '0;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts unanswered strobe cycles, forces a one-cycle err at the
// limit, and keeps a sticky flag plus a saturating count of forced errors.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stb_active,
    input  logic                 resp_seen,
    input  logic                 clr,
    output logic                 force_err,
    output logic                 timeout_flag,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // A response on the limit cycle wins, so the forced err never overlaps one.
    assign force_err = stb_active && !resp_seen && (wait_cnt == CNT_LAST);

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
            err_cnt      <= '0;
        end else begin
            if (!stb_active || resp_seen || force_err)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;

            if (force_err) begin
                timeout_flag <= 1'b1;
                if (clr)
                    err_cnt <= ERR_CNT_W'(1);
                else if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end else if (clr) begin
                timeout_flag <= 1'b0;
                err_cnt      <= '0;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter with LOCK support and a watchdog
// that terminates stalled strobes with a forced err.
module wb_bus_arbiter
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [WB_ADDR_W-1:0] m0_addr_i,
    input  logic [WB_DATA_W-1:0] m0_dat_i,
    input  logic                 m0_we_i,
    input  logic [WB_SEL_W-1:0]  m0_sel_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_lock_i,
    output logic [WB_DATA_W-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    output logic                 m0_rty_o,

    input  logic [WB_ADDR_W-1:0] m1_addr_i,
    input  logic [WB_DATA_W-1:0] m1_dat_i,
    input  logic                 m1_we_i,
    input  logic [WB_SEL_W-1:0]  m1_sel_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_lock_i,
    output logic [WB_DATA_W-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    output logic                 m1_rty_o,

    output logic [WB_ADDR_W-1:0] s_addr_o,
    output logic [WB_DATA_W-1:0] s_dat_o,
    output logic                 s_we_o,
    output logic [WB_SEL_W-1:0]  s_sel_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_lock_o,
    input  logic [WB_DATA_W-1:0] s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic                 s_rty_i,

    output logic [1:0]           grant_o,
    output logic                 timeout_flag_o,
    input  logic                 timeout_clr_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    wb_req_t    req0, req1, req_sel;
    wb_rsp_t    rsp0, rsp1;
    arb_state_e state;
    logic       last_served;
    logic       gnt0, gnt1;
    logic       stb_active, resp_seen, force_err;

    assign req0 = '{addr: m0_addr_i, dat: m0_dat_i, we: m0_we_i, sel: m0_sel_i,
                    cyc: m0_cyc_i, stb: m0_stb_i, lock: m0_lock_i};
    assign req1 = '{addr: m1_addr_i, dat: m1_dat_i, we: m1_we_i, sel: m1_sel_i,
                    cyc: m1_cyc_i, stb: m1_stb_i, lock: m1_lock_i};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            grant_o     <= 2'b00;
            last_served <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // On a tie the master that was not served last wins.
                    if (m0_cyc_i && (!m1_cyc_i || last_served)) begin
                        state   <= ST_GNT0;
                        grant_o <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state   <= ST_GNT1;
                        grant_o <= 2'b10;
                    end
                end
                ST_GNT0: begin
                    if (!m0_cyc_i && !m0_lock_i) begin
                        state       <= ST_IDLE;
                        grant_o     <= 2'b00;
                        last_served <= 1'b0;
                    end
                end
                ST_GNT1: begin
                    if (!m1_cyc_i && !m1_lock_i) begin
                        state       <= ST_IDLE;
                        grant_o     <= 2'b00;
                        last_served <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

    // Reset gates the grant decode so an aborted transfer never sees ack or err.
    assign gnt0 = rst_i && (state == ST_GNT0);
    assign gnt1 = rst_i && (state == ST_GNT1);

    always_comb begin
        req_sel = '0;
        if (gnt0)
            req_sel = req0;
        else if (gnt1)
            req_sel = req1;
    end

    assign stb_active = req_sel.cyc && req_sel.stb;
    assign resp_seen  = s_ack_i || s_err_i || s_rty_i;

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ERR_CNT_W      (ERR_CNT_W)
    ) u_watchdog (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stb_active   (stb_active),
        .resp_seen    (resp_seen),
        .clr          (timeout_clr_i),
        .force_err    (force_err),
        .timeout_flag (timeout_flag_o),
        .err_cnt      (err_cnt_o)
    );

    // NOTE: every signal gets a default before the branches, so no latch is inferred.
    always_comb begin
        rsp0 = RSP_IDLE;
        rsp1 = RSP_IDLE;
        if (gnt0) begin
            rsp0.dat = s_dat_i;
            rsp0.ack = s_ack_i & m0_stb_i;
            rsp0.err = (s_err_i & m0_stb_i) | force_err;
            rsp0.rty = s_rty_i & m0_stb_i;
        end else if (gnt1) begin
            rsp1.dat = s_dat_i;
            rsp1.ack = s_ack_i & m1_stb_i;
            rsp1.err = (s_err_i & m1_stb_i) | force_err;
            rsp1.rty = s_rty_i & m1_stb_i;
        end
    end

    assign s_addr_o = req_sel.addr;
    assign s_dat_o  = req_sel.dat;
    assign s_we_o   = req_sel.we;
    assign s_sel_o  = req_sel.sel;
    assign s_cyc_o  = req_sel.cyc;
    assign s_stb_o  = stb_active && !force_err;
    assign s_lock_o = req_sel.lock;

    assign m0_dat_o = rsp0.dat;
    assign m0_ack_o = rsp0.ack;
    assign m0_err_o = rsp0.err;
    assign m0_rty_o = rsp0.rty;
    assign m1_dat_o = rsp1.dat;
    assign m1_ack_o = rsp1.ack;
    assign m1_err_o = rsp1.err;
    assign m1_rty_o = rsp1.rty;

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master Wishbone arbiter with a bus watchdog, placed between the masters and the shared slave bus (UART and frequency counter, whose dat/err/rty/ack returns are OR-combined upstream).
- Master 0 is control_unit; master 1 is a second requester such as an autonomous measurement sequencer.
- Grants the bus round-robin, honours LOCK, and multiplexes the winning master onto the slave side.
- Terminates stalled cycles with ERR after a timeout.

Parameters:
- TIMEOUT_CYCLES, 64: cycles a strobe may wait for ack/err/rty before the arbiter forces err; legal range 2..1023.
- ERR_CNT_W, 8: width of the saturating timeout event counter.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- mN_addr_i  in  32  master N address. N=0,1; each mN_* line is one port per master.
- mN_dat_i  in  32  master N write data.
- mN_we_i  in  1  master N write enable.
- mN_sel_i  in  4  master N byte select.
- mN_cyc_i  in  1  master N cycle (bus request).
- mN_stb_i  in  1  master N strobe.
- mN_lock_i  in  1  master N lock; holds the grant.
- mN_dat_o  out  32  read data to master N.
- mN_ack_o  out  1  ack to master N.
- mN_err_o  out  1  err to master N, either slave or timeout.
- mN_rty_o  out  1  retry to master N.
- s_addr_o  out  32  shared slave address.
- s_dat_o  out  32  shared slave write data.
- s_we_o  out  1  shared slave write enable.
- s_sel_o  out  4  shared slave byte select.
- s_cyc_o  out  1  shared slave cycle.
- s_stb_o  out  1  shared slave strobe.
- s_lock_o  out  1  shared slave lock.
- s_dat_i  in  32  OR-combined slave read data.
- s_ack_i  in  1  OR-combined slave ack.
- s_err_i  in  1  OR-combined slave err.
- s_rty_i  in  1  OR-combined slave retry.
- grant_o  out  2  one-hot current grant: bit0 = m0, bit1 = m1, 00 = idle.
- timeout_flag_o  out  1  sticky; set on any forced err.
- timeout_clr_i  in  1  clears timeout_flag_o and err_cnt_o.
- err_cnt_o  out  ERR_CNT_W  saturating count of forced errors.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - State IDLE, grant_o=00.
  - All s_* outputs 0 and all mN_* outputs 0.
  - Timeout counter, timeout_flag_o and err_cnt_o all 0.
  - last_served=1, so m0 wins the first tie.
  - Reset mid-transfer aborts silently: no ack or err is issued.
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - Only m0_cyc_i=1 -> GNT0. Only m1_cyc_i=1 -> GNT1.
  - Both high -> grant the master that is not last_served.
  - The grant is registered: one cycle from cyc to grant; s_cyc_o rises in the first GNT cycle.
- GNTn:
  - s_addr/dat/we/sel/cyc/stb/lock_o follow master n combinationally.
  - mn_dat_o=s_dat_i; mn_ack/err/rty_o = s_*_i & mn_stb_i.
  - The non-granted master sees all-zero outputs, dat_o included.
- GNTn exit:
  - Leave to IDLE when mn_cyc_i=0 and mn_lock_i=0; last_served<=n on exit.
  - With mn_cyc_i=0 but mn_lock_i=1, hold GNTn with s_cyc_o=s_stb_o=0 and s_lock_o=1.
  - The bus is idle for at least one cycle between tenures; there is no preemption.
- Watchdog:
  - The counter increments each cycle in GNTn with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i.
  - It clears on any response, on stb low, or outside GNT.
  - At counter == TIMEOUT_CYCLES-1 with still no response, the same cycle:
    - mn_err_o=1 for exactly one cycle (forced), and s_stb_o is gated to 0 that cycle.
    - Counter clears; timeout_flag_o<=1; err_cnt_o increments, saturating at all-ones.
- Simultaneous events:
  - A slave response arriving on the timeout cycle wins: normal response passes through, no forced err, flag unchanged.
  - timeout_clr_i and a forced err in the same cycle: set wins, so the flag is 1 and the count is 1.
- Counter width is $clog2(TIMEOUT_CYCLES). A cyc drop during a wait clears the counter and exits per the rules above.

Decomposition:
- Shared package wb_pkg:
  - State encoding constants ST_IDLE/ST_GNT0/ST_GNT1.
  - Bus widths WB_ADDR_W=32, WB_DATA_W=32, WB_SEL_W=4.
  - Default TIMEOUT_CYCLES.
- One sub-module, wb_watchdog: the counter, forced-err pulse, sticky flag and saturating err_cnt. Its inputs are stb_active and resp_seen.
- Arbiter FSM and multiplexers stay in the top module.

Test Plan:
- Single request: m0 cyc/stb high, addr=0x10; slave acks in cycle 3 with dat 0xDEADBEEF -> grant_o=01 one cycle after cyc; m0_dat_o=0xDEADBEEF with m0_ack_o; m1 outputs all 0.
- Tie: m0 and m1 request in the same cycle after reset, each holds 4 cycles -> m0 granted first, IDLE 1 cycle, then m1. Repeat the tie -> m0 again, since last_served=1.
- Lock hold: m1 granted, drops cyc with lock=1 for 5 cycles while m0 requests -> grant_o stays 10, s_cyc_o=0, s_lock_o=1. m1 lock drop -> IDLE, then GNT0.
- Timeout, TIMEOUT_CYCLES=8: m0 strobes and the slave never responds -> m0_err_o pulses exactly on the 8th strobe cycle; timeout_flag_o=1; err_cnt_o=1.
- Race: slave ack on the exact timeout cycle -> m0_ack_o=1, m0_err_o=0, err_cnt_o unchanged. timeout_clr_i coincident with a forced err -> flag=1, count=1. 256 forced errors -> err_cnt_o holds at 255.
- Reset mid-cycle: rst_i=0 during a GNT1 wait -> next edge grant_o=00, all outputs 0, flag 0; first tie after release goes to m0.
